// File: rtl/lsu_bus_if.sv
// Memory-side bus between the load/store unit (master) and the memory system (slave).
interface lsu_bus_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    // A request transfers on the cycle mem_valid && mem_ready are both high; the master holds
    // every request field stable until then. mem_rsp_valid/mem_rsp_err/mem_rdata carry one
    // response per accepted request, no earlier than the cycle after the request handshake.
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_rsp_valid;
    logic              mem_rsp_err;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rsp_valid, mem_rsp_err, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rsp_valid, mem_rsp_err, mem_rdata
    );
endinterface

// File: rtl/lsu_bus.sv
// Multi-cycle load/store unit: checks legality/alignment, steers store lanes, extends loads,
// and runs one valid/ready bus transaction per core request with an optional timeout.
module lsu_bus #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_data,
    output logic [2:0]        rsp_err,
    lsu_bus_if.master         mem,
    output logic [1:0]        dbg_state
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam bit IS64 = (XLEN == 64);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_MISALIGN = 3'd1;
    localparam logic [2:0] ERR_BUS     = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_FUNCT3  = 3'd4;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              we_q, we_n;
    logic [2:0]        f3_q, f3_n;
    logic [OFF_W-1:0]  off_q, off_n;
    logic              req_ready_n, rsp_valid_n;
    logic [XLEN-1:0]   rsp_data_n;
    logic [2:0]        rsp_err_n;
    logic              mvalid_n, mwe_n;
    logic [ADDR_W-1:0] maddr_n;
    logic [XLEN-1:0]   mwdata_n;
    logic [NB-1:0]     mwstrb_n;

    logic              legal, misaligned, timeout_hit;
    logic [XLEN-1:0]   repl_wdata, shifted, load_data;
    logic [NB-1:0]     strb_base;

    assign dbg_state   = state;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_CNT);
    assign shifted     = mem.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        legal      = 1'b1;
        misaligned = 1'b0;
        repl_wdata = req_wdata;
        strb_base  = '0;
        if (req_we) begin
            legal = (req_funct3 <= 3'd2) || (req_funct3 == 3'd3 && IS64);
        end else begin
            case (req_funct3)
                3'd3, 3'd6: legal = IS64;
                3'd7:       legal = 1'b0;
                default:    legal = 1'b1;
            endcase
        end
        case (req_funct3[1:0])
            2'd0: begin
                repl_wdata = {NB{req_wdata[7:0]}};
                strb_base  = NB'(1);
            end
            2'd1: begin
                misaligned = req_addr[0];
                repl_wdata = {(XLEN/16){req_wdata[15:0]}};
                strb_base  = NB'(4'h3);
            end
            2'd2: begin
                misaligned = |req_addr[1:0];
                repl_wdata = {(XLEN/32){req_wdata[31:0]}};
                strb_base  = NB'(4'hF);
            end
            default: begin
                misaligned = |req_addr[2:0];
                repl_wdata = req_wdata;
                strb_base  = NB'(8'hFF);
            end
        endcase
    end

    always_comb begin
        case (f3_q)
            3'd0:    load_data = XLEN'($signed(shifted[7:0]));
            3'd1:    load_data = XLEN'($signed(shifted[15:0]));
            3'd2:    load_data = XLEN'($signed(shifted[31:0]));
            3'd4:    load_data = XLEN'(shifted[7:0]);
            3'd5:    load_data = XLEN'(shifted[15:0]);
            3'd6:    load_data = XLEN'(shifted[31:0]);
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        we_n        = we_q;
        f3_n        = f3_q;
        off_n       = off_q;
        mvalid_n    = mem.mem_valid;
        mwe_n       = mem.mem_we;
        maddr_n     = mem.mem_addr;
        mwdata_n    = mem.mem_wdata;
        mwstrb_n    = mem.mem_wstrb;
        rsp_valid_n = 1'b0;
        rsp_data_n  = '0;
        rsp_err_n   = ERR_NONE;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    we_n  = req_we;
                    f3_n  = req_funct3;
                    off_n = req_addr[OFF_W-1:0];
                    if (!legal) begin
                        state_n     = DONE;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = ERR_FUNCT3;
                    end else if (misaligned) begin
                        state_n     = DONE;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = ERR_MISALIGN;
                    end else begin
                        state_n  = REQ;
                        cnt_n    = '0;
                        mvalid_n = 1'b1;
                        mwe_n    = req_we;
                        maddr_n  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mwdata_n = repl_wdata;
                        mwstrb_n = req_we ? (strb_base << req_addr[OFF_W-1:0]) : '0;
                    end
                end
            end
            REQ: begin
                // Timeout wins over a handshake landing in the same cycle.
                if (timeout_hit) begin
                    state_n     = DONE;
                    mvalid_n    = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = ERR_TIMEOUT;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (mem.mem_ready) begin
                        state_n  = WAIT;
                        mvalid_n = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (timeout_hit) begin
                    state_n     = DONE;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = ERR_TIMEOUT;
                end else if (mem.mem_rsp_valid) begin
                    state_n     = DONE;
                    rsp_valid_n = 1'b1;
                    if (mem.mem_rsp_err) rsp_err_n = ERR_BUS;
                    else if (!we_q)      rsp_data_n = load_data;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        req_ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            f3_q          <= 3'd0;
            off_q         <= '0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= ERR_NONE;
            mem.mem_valid <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            we_q          <= we_n;
            f3_q          <= f3_n;
            off_q         <= off_n;
            req_ready     <= req_ready_n;
            rsp_valid     <= rsp_valid_n;
            rsp_data      <= rsp_data_n;
            rsp_err       <= rsp_err_n;
            mem.mem_valid <= mvalid_n;
            mem.mem_we    <= mwe_n;
            mem.mem_addr  <= maddr_n;
            mem.mem_wdata <= mwdata_n;
            mem.mem_wstrb <= mwstrb_n;
        end
    end
endmodule

// File: tb/tb_lsu_bus.sv
// Randomized scoreboard bench for lsu_bus (RV32, short timeout) with a spec-level reference model.
module tb_lsu_bus;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int TO     = 6;
    localparam int NB     = XLEN / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [XLEN-1:0]   req_wdata = '0;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_data;
    logic [2:0]        rsp_err;
    logic [1:0]        dbg_state;

    lsu_bus_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    lsu_bus #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem(bus), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [XLEN+2:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: legality, alignment and load extension from the ISA rules.
    function automatic bit model_legal(input bit we, input logic [2:0] f3);
        if (we) return (f3 <= 3'd2) || (f3 == 3'd3 && XLEN == 64);
        return (f3 != 3'd7) && ((f3 != 3'd3 && f3 != 3'd6) || XLEN == 64);
    endfunction

    function automatic int model_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [XLEN-1:0] model_load(input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                                                   input logic [XLEN-1:0] rdata);
        int sz = model_size(f3);
        int off = int'(addr % NB);
        logic [63:0] v = 64'(rdata) >> (8 * off);
        logic [63:0] res = '0;
        for (int i = 0; i < sz; i++) res[8*i +: 8] = v[8*i +: 8];
        if (!f3[2] && res[8*sz-1])
            for (int i = 8 * sz; i < 64; i++) res[i] = 1'b1;
        return res[XLEN-1:0];
    endfunction

    // One core operation plus the memory-side responder. Called and returns at a negedge.
    task automatic do_op(input bit we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                         input logic [XLEN-1:0] wd, input logic [XLEN-1:0] rd, input bit berr,
                         input int d_r, input int d_s, input bit noise);
        int sz = model_size(f3);
        int off = int'(addr % NB);
        bit legal = model_legal(we, f3);
        bit pre_err = !legal || (addr % sz != 0);
        bit timed_out = !pre_err && (d_r + 1 + d_s >= TO);
        logic [2:0] e_err;
        logic [XLEN-1:0] e_data = '0;
        logic [XLEN-1:0] e_wdata;
        logic [NB-1:0] e_strb = '0;
        int e_lat, r = -1, hs = -1;
        bit done = 0, saw_mv = 0;

        if (!legal) e_err = 3'd4;
        else if (addr % sz != 0) e_err = 3'd1;
        else if (timed_out) e_err = 3'd3;
        else if (berr) e_err = 3'd2;
        else e_err = 3'd0;
        if (e_err == 3'd0 && !we) e_data = model_load(f3, addr, rd);
        e_lat = pre_err ? 1 : (timed_out ? TO + 2 : d_r + d_s + 3);
        for (int i = 0; i < NB; i++) e_wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
        if (we) for (int i = off; i < off + sz && i < NB; i++) e_strb[i] = 1'b1;

        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        exp_q.push_back({e_err, e_data});
        @(negedge clk);
        req_valid = 1'b0; req_wdata = XLEN'($urandom); req_addr = ADDR_W'($urandom);
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            if (cyc > 1) @(negedge clk);
            bus.mem_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_err = 1'b0;
            bus.mem_rdata = XLEN'($urandom);
            if (rsp_valid) begin
                done = 1;
                check("latency", 64'(cyc), 64'(e_lat));
                check("req_ready_busy", 64'(req_ready), 64'd0);
            end else if (bus.mem_valid) begin
                if (r < 0) begin
                    r = cyc; saw_mv = 1;
                    check("mem_valid_cycle", 64'(r), 64'd1);
                    check("mem_addr", 64'(bus.mem_addr), 64'(addr - addr % NB));
                    check("mem_we", 64'(bus.mem_we), 64'(we));
                    check("mem_wstrb", 64'(bus.mem_wstrb), 64'(e_strb));
                    if (we) check("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
                end
                if (cyc - r >= d_r) begin
                    bus.mem_ready = 1'b1; hs = cyc;
                end else if (noise && $urandom_range(0, 1) == 1) begin
                    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_err = 1'($urandom);
                end
            end else if (hs > 0 && cyc == hs + 1 + d_s) begin
                bus.mem_rsp_valid = 1'b1; bus.mem_rsp_err = berr; bus.mem_rdata = rd;
            end
        end
        check("rsp_arrived", 64'(done), 64'd1);
        check("bus_activity", 64'(saw_mv), 64'(!pre_err));
        // Idle gap; stale responses here must be ignored.
        @(negedge clk);
        bus.mem_ready = 1'b0; bus.mem_rsp_err = 1'($urandom);
        bus.mem_rsp_valid = noise ? 1'($urandom) : 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
    endtask

    // Monitor: every rsp_valid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp: got err=%0d data=0x%0h with nothing expected", rsp_err, rsp_data);
            end else begin
                logic [XLEN+2:0] e;
                e = exp_q.pop_front();
                check("rsp_err", 64'(rsp_err), 64'(e[XLEN+2:XLEN]));
                check("rsp_data", 64'(rsp_data), 64'(e[XLEN-1:0]));
            end
        end
    end

    initial begin
        bus.mem_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_err = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_outputs", 64'({rsp_data, rsp_err, bus.mem_wstrb}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(0, 3'd0, 32'h1003, '0, 32'h80FF_0000, 0, 0, 0, 0);   // LB sign-extend
        do_op(1, 3'd1, 32'h2002, 32'h1234_ABCD, '0, 0, 1, 0, 0);  // SH upper half
        do_op(0, 3'd2, 32'h1002, '0, '0, 0, 0, 0, 0);              // misaligned LW
        do_op(0, 3'd6, 32'h8004, '0, '0, 0, 0, 0, 0);              // LWU illegal on RV32
        do_op(1, 3'd3, 32'h8000, '0, '0, 0, 0, 0, 0);              // SD illegal on RV32
        do_op(0, 3'd7, 32'h8001, '0, '0, 0, 0, 0, 0);              // illegal beats misaligned
        do_op(0, 3'd2, 32'h0040, '0, 32'h1, 0, 20, 0, 1);          // mem_ready held low
        do_op(0, 3'd5, 32'h0042, '0, 32'hBEEF_0000, 0, 0, 0, 0);   // LHU upper half

        // Reset while in WAIT abandons the operation with no response.
        check("pre_rst_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h3000;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_mem_valid", 64'(bus.mem_valid), 64'd1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check("wait_mem_valid", 64'(bus.mem_valid), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ready", 64'(req_ready), 64'd1);
        check("async_rst_valids", 64'({bus.mem_valid, rsp_valid}), 64'd0);
        check("async_rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(0, 3'd2, 32'h0100, '0, 32'hDEAD_BEEF, 0, 1, 1, 0);   // LW after reset
        do_op(0, 3'd1, 32'h0102, '0, 32'h8000_0000, 1, 0, 0, 0);   // bus error
        do_op(1, 3'd2, 32'h0200, 32'hCAFE_F00D, '0, 0, 2, 2, 1);   // SW

        for (int n = 0; n < 200; n++) begin
            logic [ADDR_W-1:0] a = ADDR_W'($urandom);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_op(1'($urandom), 3'($urandom), a, XLEN'($urandom), XLEN'($urandom),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
